// File: rtl/uart_stim_tx.sv
// uart_stim_tx
// Bench-side UART transmitter. Bytes written into an internal FIFO are sent
// LSB first as 8 data bits, with optional even/odd parity and 1 or 2 stop
// bits. Every bit lasts BAUD_DIV clocks. Frames are sent back to back while
// the FIFO holds data.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   wr_en_i    byte write strobe; accepted when full_o is low
//   wr_data_i  byte to transmit
//   full_o     FIFO full (registered)
//   empty_o    FIFO empty (registered)
//   level_o    FIFO occupancy (registered)
//   busy_o     high while a frame is on the line
//   ovf_o      sticky overflow: a write arrived while full_o was high
//   tx_o       serial line output (registered), idles high
module uart_stim_tx #(
    parameter int unsigned BAUD_DIV  = 434,
    parameter int unsigned FIFO_AW   = 4,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic [7:0]       wr_data_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [FIFO_AW:0] level_o,
    output logic             busy_o,
    output logic             ovf_o,
    output logic             tx_o
);

    localparam int unsigned DEPTH       = 1 << FIFO_AW;
    localparam logic [15:0] BAUD_RELOAD = 16'(BAUD_DIV - 1);
    localparam logic [2:0]  LAST_STOP   = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t           state;
    logic [7:0]       mem [DEPTH];
    logic [FIFO_AW:0] wr_ptr, rd_ptr, wr_ptr_nx, rd_ptr_nx;
    logic [15:0]      baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_q;
    logic             par_q;
    logic [7:0]       head;
    logic             do_wr, do_pop, bit_done, stop_done;

    assign head      = mem[rd_ptr[FIFO_AW-1:0]];
    assign bit_done  = (baud_cnt == '0);
    assign stop_done = (state == STOP) && bit_done && (bit_idx == LAST_STOP);

    // Both decisions use the registered flags, so a write that lands on a
    // full FIFO is dropped even if a pop frees a slot on the same edge.
    assign do_wr  = wr_en_i && !full_o;
    assign do_pop = !empty_o && ((state == IDLE) || stop_done);

    always_comb begin
        wr_ptr_nx = wr_ptr + {{FIFO_AW{1'b0}}, do_wr};
        rd_ptr_nx = rd_ptr + {{FIFO_AW{1'b0}}, do_pop};
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr[FIFO_AW-1:0]] <= wr_data_i;
        end
    end

    // Flags are computed from the next pointers so they are valid on the
    // edge after the write/pop that changes them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            full_o  <= 1'b0;
            empty_o <= 1'b1;
            level_o <= '0;
            ovf_o   <= 1'b0;
        end else begin
            wr_ptr  <= wr_ptr_nx;
            rd_ptr  <= rd_ptr_nx;
            full_o  <= (wr_ptr_nx[FIFO_AW] != rd_ptr_nx[FIFO_AW]) &&
                       (wr_ptr_nx[FIFO_AW-1:0] == rd_ptr_nx[FIFO_AW-1:0]);
            empty_o <= (wr_ptr_nx == rd_ptr_nx);
            level_o <= wr_ptr_nx - rd_ptr_nx;
            if (wr_en_i && full_o) begin
                ovf_o <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            tx_o     <= 1'b1;
            busy_o   <= 1'b0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    tx_o <= 1'b1;
                    if (do_pop) begin
                        shift_q  <= head;
                        par_q    <= (PARITY == 2) ? ~(^head) : ^head;
                        baud_cnt <= BAUD_RELOAD;
                        tx_o     <= 1'b0;
                        busy_o   <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    if (bit_done) begin
                        baud_cnt <= BAUD_RELOAD;
                        bit_idx  <= '0;
                        tx_o     <= shift_q[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        baud_cnt <= BAUD_RELOAD;
                        if (bit_idx == 3'd7) begin
                            bit_idx <= '0;
                            if (PARITY != 0) begin
                                tx_o  <= par_q;
                                state <= PAR;
                            end else begin
                                tx_o  <= 1'b1;
                                state <= STOP;
                            end
                        end else begin
                            // Shift register keeps the next bit in position 1.
                            bit_idx <= bit_idx + 3'd1;
                            tx_o    <= shift_q[1];
                            shift_q <= {1'b0, shift_q[7:1]};
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                PAR: begin
                    if (bit_done) begin
                        baud_cnt <= BAUD_RELOAD;
                        bit_idx  <= '0;
                        tx_o     <= 1'b1;
                        state    <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        baud_cnt <= BAUD_RELOAD;
                        if (bit_idx == LAST_STOP) begin
                            bit_idx <= '0;
                            if (do_pop) begin
                                // Back-to-back: next start bit with no idle gap.
                                shift_q <= head;
                                par_q   <= (PARITY == 2) ? ~(^head) : ^head;
                                tx_o    <= 1'b0;
                                state   <= START;
                            end else begin
                                busy_o <= 1'b0;
                                state  <= IDLE;
                            end
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx_o  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_stim_tx.sv
module tb_uart_stim_tx;

    localparam int unsigned A_BAUD = 4, A_AW = 4, A_PAR = 0, A_STOP = 1;
    localparam int unsigned B_BAUD = 4, B_AW = 2, B_PAR = 1, B_STOP = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wen [2];
    logic [7:0] wdat [2];
    logic       chk_en = 1'b0;

    logic            full_a, empty_a, busy_a, ovf_a, tx_a;
    logic [A_AW:0]   level_a;
    logic            full_b, empty_b, busy_b, ovf_b, tx_b;
    logic [B_AW:0]   level_b;

    logic d_tx [2], d_busy [2], d_full [2], d_empty [2], d_ovf [2];
    int   d_lvl [2];

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    uart_stim_tx #(.BAUD_DIV(A_BAUD), .FIFO_AW(A_AW), .PARITY(A_PAR), .STOP_BITS(A_STOP)) u_a (
        .clk(clk), .rst_n(rst_n), .wr_en_i(wen[0]), .wr_data_i(wdat[0]),
        .full_o(full_a), .empty_o(empty_a), .level_o(level_a),
        .busy_o(busy_a), .ovf_o(ovf_a), .tx_o(tx_a)
    );

    uart_stim_tx #(.BAUD_DIV(B_BAUD), .FIFO_AW(B_AW), .PARITY(B_PAR), .STOP_BITS(B_STOP)) u_b (
        .clk(clk), .rst_n(rst_n), .wr_en_i(wen[1]), .wr_data_i(wdat[1]),
        .full_o(full_b), .empty_o(empty_b), .level_o(level_b),
        .busy_o(busy_b), .ovf_o(ovf_b), .tx_o(tx_b)
    );

    assign d_tx[0] = tx_a;       assign d_tx[1] = tx_b;
    assign d_busy[0] = busy_a;   assign d_busy[1] = busy_b;
    assign d_full[0] = full_a;   assign d_full[1] = full_b;
    assign d_empty[0] = empty_a; assign d_empty[1] = empty_b;
    assign d_ovf[0] = ovf_a;     assign d_ovf[1] = ovf_b;
    assign d_lvl[0] = int'(level_a);
    assign d_lvl[1] = int'(level_b);

    function automatic int m_baud(int i);  return (i == 0) ? A_BAUD : B_BAUD; endfunction
    function automatic int m_par(int i);   return (i == 0) ? A_PAR : B_PAR; endfunction
    function automatic int m_stop(int i);  return (i == 0) ? A_STOP : B_STOP; endfunction
    function automatic int m_depth(int i); return (i == 0) ? (1 << A_AW) : (1 << B_AW); endfunction
    function automatic int flen(int i);
        return (9 + ((m_par(i) != 0) ? 1 : 0) + m_stop(i)) * m_baud(i);
    endfunction

    // Line level at a given position inside a frame carrying byte d.
    function automatic logic exp_bit(int i, int pos, logic [7:0] d);
        int b;
        b = pos / m_baud(i);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (m_par(i) != 0 && b == 9) return (m_par(i) == 1) ? ^d : ~(^d);
        return 1'b1;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: byte queue plus position inside the current frame.
    logic [7:0] mq [2][$];
    int         mpos [2] = '{-1, -1};
    logic [7:0] mbyte [2] = '{8'h00, 8'h00};
    logic       movf [2] = '{1'b0, 1'b0};
    int         npre;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                mq[i].delete();
                mpos[i] = -1;
                movf[i] = 1'b0;
            end else begin
                npre = mq[i].size();
                if (npre > 0 && (mpos[i] < 0 || mpos[i] == flen(i) - 1)) begin
                    mbyte[i] = mq[i].pop_front();
                    mpos[i] = 0;
                end else if (mpos[i] == flen(i) - 1) begin
                    mpos[i] = -1;
                end else if (mpos[i] >= 0) begin
                    mpos[i]++;
                end
                if (wen[i]) begin
                    if (npre < m_depth(i)) mq[i].push_back(wdat[i]);
                    else movf[i] = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                string s;
                s = (i == 0) ? "a" : "b";
                chk({"tx_", s}, 32'(d_tx[i]), 32'((mpos[i] < 0) ? 1'b1 : exp_bit(i, mpos[i], mbyte[i])));
                chk({"busy_", s}, 32'(d_busy[i]), 32'(mpos[i] >= 0));
                chk({"level_", s}, 32'(d_lvl[i]), 32'(mq[i].size()));
                chk({"empty_", s}, 32'(d_empty[i]), 32'(mq[i].size() == 0));
                chk({"full_", s}, 32'(d_full[i]), 32'(mq[i].size() == m_depth(i)));
                chk({"ovf_", s}, 32'(d_ovf[i]), 32'(movf[i]));
            end
        end
    end

    // Line decoder: finds a start bit and samples each bit mid-cell.
    int         rpos [2] = '{-1, -1};
    logic [7:0] rbyte [2];
    logic [7:0] dq [2][$];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                rpos[i] = -1;
            end else if (rpos[i] < 0) begin
                if (d_tx[i] === 1'b0) rpos[i] = 0;
            end else begin
                rpos[i]++;
                if ((rpos[i] % m_baud(i)) == m_baud(i) / 2 &&
                    rpos[i] / m_baud(i) >= 1 && rpos[i] / m_baud(i) <= 8)
                    rbyte[i][rpos[i] / m_baud(i) - 1] = d_tx[i];
                if (rpos[i] == flen(i) - 1) begin
                    dq[i].push_back(rbyte[i]);
                    rpos[i] = -1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [9:0]  fa;
        logic [11:0] fb;
        logic [7:0]  exp_q [$];
        int          busy_cnt;

        wen[0] = 1'b1; wen[1] = 1'b1;
        wdat[0] = 8'hAA; wdat[1] = 8'hBB;
        rst_n = 1'b0;

        // Reset held for 3 clocks with writes requested.
        tick();
        chk_en = 1'b1;
        tick();
        tick();
        chk("rst_level_a", 32'(level_a), 32'd0);
        chk("rst_tx_a", 32'(tx_a), 32'd1);
        chk("rst_empty_b", 32'(empty_b), 32'd1);
        chk("rst_busy_b", 32'(busy_b), 32'd0);
        rst_n = 1'b1;
        wen[0] = 1'b0; wen[1] = 1'b0;
        repeat (3) tick();

        // Single byte 0x55 on 8N1.
        fa = 10'b1_01010101_0;
        wen[0] = 1'b1; wdat[0] = 8'h55;
        tick();
        wen[0] = 1'b0;
        chk("wr_level_a", 32'(level_a), 32'd1);
        chk("wr_empty_a", 32'(empty_a), 32'd0);
        for (int k = 1; k <= 41; k++) begin
            tick();
            if (k <= 40) chk("frame55_tx", 32'(tx_a), 32'(fa[(k - 1) / 4]));
            chk("frame55_busy", 32'(busy_a), 32'(k <= 40));
            if (k == 1) chk("pop_level_a", 32'(level_a), 32'd0);
        end
        repeat (3) tick();

        // Even parity, 2 stop bits, 0x07: parity bit 1, 48-clock frame.
        fb = 12'b11_1_00000111_0;
        wen[1] = 1'b1; wdat[1] = 8'h07;
        tick();
        wen[1] = 1'b0;
        for (int k = 1; k <= 49; k++) begin
            tick();
            if (k <= 48) chk("frame07_tx", 32'(tx_b), 32'(fb[(k - 1) / 4]));
            chk("frame07_busy", 32'(busy_b), 32'(k <= 48));
        end
        chk("dec07_cnt", 32'(dq[1].size()), 32'd1);
        if (dq[1].size() == 1) chk("dec07_val", 32'(dq[1][0]), 32'h07);
        dq[1].delete();

        // Back-to-back: three writes on consecutive edges.
        exp_q = '{8'hA5, 8'h3C, 8'hFF};
        busy_cnt = 0;
        wen[0] = 1'b1;
        for (int n = 0; n < 3; n++) begin
            wdat[0] = exp_q[n];
            tick();
            if (busy_a) busy_cnt++;
        end
        wen[0] = 1'b0;
        chk("b2b_level_peak", 32'(level_a), 32'd2);
        for (int k = 3; k <= 130; k++) begin
            tick();
            if (busy_a) busy_cnt++;
        end
        chk("b2b_busy_cycles", 32'(busy_cnt), 32'd120);
        exp_q.push_front(8'h55);
        chk("b2b_dec_cnt", 32'(dq[0].size()), 32'd4);
        for (int n = 0; n < 4; n++)
            if (n < dq[0].size()) chk("b2b_dec_val", 32'(dq[0][n]), 32'(exp_q[n]));
        dq[0].delete();

        // Full/overflow on the depth-4 instance.
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        wen[1] = 1'b1;
        for (int n = 0; n < 6; n++) begin
            wdat[1] = exp_q[n];
            tick();
            if (n == 4) begin
                chk("full_after5", 32'(full_b), 32'd1);
                chk("ovf_before", 32'(ovf_b), 32'd0);
            end
        end
        wen[1] = 1'b0;
        chk("ovf_set", 32'(ovf_b), 32'd1);
        chk("full_level", 32'(level_b), 32'd4);
        repeat (5 * 48 + 20) tick();
        chk("drain_cnt", 32'(dq[1].size()), 32'd5);
        for (int n = 0; n < 5; n++)
            if (n < dq[1].size()) chk("drain_val", 32'(dq[1][n]), 32'(exp_q[n]));
        chk("ovf_sticky", 32'(ovf_b), 32'd1);
        dq[1].delete();

        // Reset during data bit 3 with bytes still queued.
        exp_q = '{8'hF0, 8'h12, 8'h34};
        wen[0] = 1'b1;
        for (int n = 0; n < 3; n++) begin
            wdat[0] = exp_q[n];
            tick();
        end
        wen[0] = 1'b0;
        repeat (15) tick();
        rst_n = 1'b0;
        tick();
        chk("midrst_tx", 32'(tx_a), 32'd1);
        chk("midrst_empty", 32'(empty_a), 32'd1);
        chk("midrst_level", 32'(level_a), 32'd0);
        rst_n = 1'b1;
        dq[0].delete();
        dq[1].delete();
        wen[0] = 1'b1; wdat[0] = 8'h81;
        tick();
        wen[0] = 1'b0;
        repeat (45) tick();
        chk("post_rst_cnt", 32'(dq[0].size()), 32'd1);
        if (dq[0].size() == 1) chk("post_rst_val", 32'(dq[0][0]), 32'h81);

        // Random traffic on both instances, checked cycle by cycle.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++) begin
                wen[i] = ($urandom_range(0, 5) == 0);
                wdat[i] = 8'($urandom);
            end
            tick();
        end
        wen[0] = 1'b0; wen[1] = 1'b0;
        repeat (800) tick();

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
